writeback_unit: RTL and testbench

//  Final pipeline stage. Accepts one retiring instruction from execute (itype, rd, funct3, result),

---
 rtl/writeback_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_writeback_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Final pipeline stage. Takes one retiring instruction from execute, performs
// the data-memory read for loads, and drives the register-file write port in
// decode. Only one instruction is in flight at a time; execute is held off
// through ex_ready_o while the unit is busy.
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | ready for a new instruction; non-writing classes consumed here
//   ST_MEM   | load request outstanding, waiting for mem_ack_i or timeout
//   ST_WRITE | register write presented for one cycle, then back to ST_IDLE
//
// Ports:
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   ex_valid_i   in   1   execute presents an instruction this cycle
//   ex_ready_o   out  1   unit can accept (transfer on ex_valid_i && ex_ready_o)
//   itype_i      in   5   instruction class (RTYPE/ITYPE/STYPE/BTYPE/LTYPE/UTYPE)
//   rd_i         in   5   destination register index
//   funct3_i     in   3   load width/sign select (LTYPE only)
//   result_i     in   32  ALU/U-type result, or byte address for LTYPE
//   mem_req_o    out  1   data-memory read request, held until ack/timeout
//   mem_addr_o   out  32  word-aligned read address
//   mem_ack_i    in   1   read data valid on mem_rdata_i this cycle
//   mem_rdata_i  in   32  read word, little-endian
//   wd_o         out  32  register write data
//   wd_rd_o      out  5   register write index
//   wd_q_o       out  1   one-cycle write strobe
//   err_o        out  1   sticky: misaligned/illegal load or memory timeout
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [4:0]  itype_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] result_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] wd_o,
  output logic [4:0]  wd_rd_o,
  output logic        wd_q_o,
  output logic        err_o
);

  // Instruction class codes shared with execute.
  localparam logic [4:0] ITYPE_R = 5'd0;
  localparam logic [4:0] ITYPE_I = 5'd1;
  localparam logic [4:0] ITYPE_S = 5'd2;
  localparam logic [4:0] ITYPE_B = 5'd3;
  localparam logic [4:0] ITYPE_L = 5'd4;
  localparam logic [4:0] ITYPE_U = 5'd5;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MEM   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_n;
  logic [4:0]           rd_q, rd_n;
  logic [2:0]           f3_q, f3_n;
  logic [1:0]           off_q, off_n;

  logic                 ready_n;
  logic                 req_n;
  logic [31:0]          addr_n;
  logic [31:0]          wd_n;
  logic [4:0]           wd_rd_n;
  logic                 wd_q_n;
  logic                 err_n;

  logic                 transfer;
  logic                 load_ok;
  logic [31:0]          load_data;
  logic [31:0]          byte_word;
  logic [7:0]           load_byte;
  logic [15:0]          load_half;

  assign transfer = ex_valid_i && ex_ready_o;

  // A load is accepted only for a known width at a naturally aligned address.
  always_comb begin
    load_ok = 1'b0;
    case (funct3_i)
      F3_LB, F3_LBU: load_ok = 1'b1;
      F3_LH, F3_LHU: load_ok = (result_i[0] == 1'b0);
      F3_LW:         load_ok = (result_i[1:0] == 2'b00);
      default:       load_ok = 1'b0;
    endcase
  end

  // Lane extraction from the returned word using the byte offset captured
  // at accept time (mem_addr_o itself is word aligned).
  assign byte_word = mem_rdata_i >> {off_q, 3'b000};
  assign load_byte = byte_word[7:0];
  assign load_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

  always_comb begin
    load_data = mem_rdata_i;
    case (f3_q)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LW:   load_data = mem_rdata_i;
      F3_LBU:  load_data = {24'd0, load_byte};
      F3_LHU:  load_data = {16'd0, load_half};
      default: load_data = mem_rdata_i;
    endcase
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rd_n    = rd_q;
    f3_n    = f3_q;
    off_n   = off_q;
    ready_n = ex_ready_o;
    req_n   = mem_req_o;
    addr_n  = mem_addr_o;
    wd_n    = wd_o;
    wd_rd_n = wd_rd_o;
    wd_q_n  = 1'b0;
    err_n   = err_o;

    case (state_q)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (transfer) begin
          rd_n  = rd_i;
          f3_n  = funct3_i;
          off_n = result_i[1:0];
          case (itype_i)
            ITYPE_R, ITYPE_I, ITYPE_U: begin
              state_n = ST_WRITE;
              ready_n = 1'b0;
              wd_n    = result_i;
              wd_rd_n = rd_i;
              wd_q_n  = (rd_i != 5'd0);
            end
            ITYPE_L: begin
              if (load_ok) begin
                state_n = ST_MEM;
                ready_n = 1'b0;
                req_n   = 1'b1;
                addr_n  = {result_i[31:2], 2'b00};
                cnt_n   = '0;
              end else begin
                err_n = 1'b1;
              end
            end
            // Stores, branches and unknown classes retire with no write.
            ITYPE_S, ITYPE_B: ;
            default: ;
          endcase
        end
      end

      ST_MEM: begin
        ready_n = 1'b0;
        // Ack on the last counted cycle still completes the load.
        if (mem_ack_i) begin
          state_n = ST_WRITE;
          req_n   = 1'b0;
          wd_n    = load_data;
          wd_rd_n = rd_q;
          wd_q_n  = (rd_q != 5'd0);
        end else if (cnt_q == CNT_LAST) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          req_n   = 1'b0;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_ONE;
        end
      end

      ST_WRITE: begin
        // Always return through IDLE so consecutive strobes have a low gap.
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end

      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_q       <= 5'd0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      ex_ready_o <= 1'b1;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'd0;
      wd_o       <= 32'd0;
      wd_rd_o    <= 5'd0;
      wd_q_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      rd_q       <= rd_n;
      f3_q       <= f3_n;
      off_q      <= off_n;
      ex_ready_o <= ready_n;
      mem_req_o  <= req_n;
      mem_addr_o <= addr_n;
      wd_o       <= wd_n;
      wd_rd_o    <= wd_rd_n;
      wd_q_o     <= wd_q_n;
      err_o      <= err_n;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Self-checking bench for writeback_unit. Each scenario task drives stimulus
// and compares the DUT against expectations computed from the block's rules
// (instruction class, load width/sign, alignment, timeout budget).
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int MEM_TIMEOUT = 16;

  localparam logic [4:0] C_R = 5'd0;
  localparam logic [4:0] C_I = 5'd1;
  localparam logic [4:0] C_S = 5'd2;
  localparam logic [4:0] C_B = 5'd3;
  localparam logic [4:0] C_L = 5'd4;
  localparam logic [4:0] C_U = 5'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [4:0]  itype_i = 5'd0;
  logic [4:0]  rd_i = 5'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] result_i = 32'd0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic [31:0] wd_o;
  logic [4:0]  wd_rd_o;
  logic        wd_q_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  // Model of the held write-port contents.
  logic [31:0] m_wd = 32'd0;

  writeback_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .TIMEOUT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid_i  (ex_valid_i),
    .ex_ready_o  (ex_ready_o),
    .itype_i     (itype_i),
    .rd_i        (rd_i),
    .funct3_i    (funct3_i),
    .result_i    (result_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .wd_o        (wd_o),
    .wd_rd_o     (wd_rd_o),
    .wd_q_o      (wd_q_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected load result from width, signedness and byte offset.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned off;
    int unsigned b;
    int unsigned h;
    int v;
    off = addr % 4;
    b = (w / (32'd1 << (off * 8))) % 256;
    h = (w / (32'd1 << ((off / 2) * 16))) % 65536;
    case (f3)
      3'd0: begin v = int'(b); if (v >= 128) v = v - 256; return 32'(v); end
      3'd1: begin v = int'(h); if (v >= 32768) v = v - 65536; return 32'(v); end
      3'd2: return w;
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic bit load_legal(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (addr % 2) == 0;
      3'd2:       return (addr % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_wd = 32'd0;
  endtask

  // Presents one instruction for a single cycle; returns just after the edge.
  task automatic issue(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] res);
    ex_valid_i = 1'b1;
    itype_i = it;
    rd_i = rd;
    funct3_i = f3;
    result_i = res;
    tick();
    ex_valid_i = 1'b0;
    itype_i = 5'($urandom);
    rd_i = 5'($urandom);
    funct3_i = 3'($urandom);
    result_i = $urandom;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", ex_ready_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", mem_req_o); end
    checks++; if (mem_addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
    checks++; if (wd_o !== 32'd0) begin errors++; $display("FAIL reset_wd got %h exp 0", wd_o); end
    checks++; if (wd_rd_o !== 5'd0) begin errors++; $display("FAIL reset_wd_rd got %0d exp 0", wd_rd_o); end
    checks++; if (wd_q_o !== 1'b0) begin errors++; $display("FAIL reset_wd_q got %0b exp 0", wd_q_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err_o); end
  endtask

  // One ALU/U-type op: strobe at N+1 only, ready back at N+2.
  task automatic alu_op(input logic [4:0] it, input logic [4:0] rd, input logic [31:0] res);
    bit exp_q;
    exp_q = (rd != 5'd0);
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready_before got %0b exp 1", ex_ready_o); end
    issue(it, rd, 3'($urandom), res);
    m_wd = res;
    checks++; if (wd_q_o !== exp_q) begin errors++; $display("FAIL alu_strobe rd=%0d got %0b exp %0b", rd, wd_q_o, exp_q); end
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL alu_busy got %0b exp 0", ex_ready_o); end
    if (exp_q) begin
      checks++; if (wd_o !== res) begin errors++; $display("FAIL alu_wd got %h exp %h", wd_o, res); end
      checks++; if (wd_rd_o !== rd) begin errors++; $display("FAIL alu_wd_rd got %0d exp %0d", wd_rd_o, rd); end
    end
    tick();
    checks++; if (wd_q_o !== 1'b0) begin errors++; $display("FAIL alu_strobe_drop got %0b exp 0", wd_q_o); end
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready_after got %0b exp 1", ex_ready_o); end
  endtask

  task automatic test_alu();
    logic [4:0] cls [3];
    cls[0] = C_R; cls[1] = C_I; cls[2] = C_U;
    alu_op(C_R, 5'd5, 32'h1234_5678);
    alu_op(C_I, 5'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 24; i++)
      alu_op(cls[$urandom_range(0, 2)], 5'($urandom_range(0, 31)), $urandom);
  endtask

  task automatic test_back_to_back();
    alu_op(C_R, 5'd1, 32'hAAAA_0001);
    alu_op(C_U, 5'd2, 32'h5555_0002);
    alu_op(C_I, 5'd3, 32'h0F0F_0003);
  endtask

  task automatic test_no_write();
    logic [4:0] it;
    for (int i = 0; i < 12; i++) begin
      if (i < 2) it = (i == 0) ? C_S : C_B;
      else it = 5'($urandom_range(6, 31));
      issue(it, 5'($urandom_range(1, 31)), 3'($urandom), $urandom);
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL nowr_ready it=%0d got %0b exp 1", it, ex_ready_o); end
      checks++; if (wd_q_o !== 1'b0) begin errors++; $display("FAIL nowr_strobe it=%0d got %0b exp 0", it, wd_q_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL nowr_req it=%0d got %0b exp 0", it, mem_req_o); end
      checks++; if (wd_o !== m_wd) begin errors++; $display("FAIL nowr_hold it=%0d got %h exp %h", it, wd_o, m_wd); end
    end
    tick();
    checks++; if (wd_q_o !== 1'b0) begin errors++; $display("FAIL nowr_strobe_late got %0b exp 0", wd_q_o); end
  endtask

  // Legal load acked after 'delay' idle MEM cycles (0..MEM_TIMEOUT-1).
  task automatic load_op(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay);
    logic [31:0] exp_v;
    bit exp_q;
    exp_v = exp_load(f3, addr, rdata);
    exp_q = (rd != 5'd0);
    issue(C_L, rd, f3, addr);
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL ld_req_start got %0b exp 1", mem_req_o); end
    checks++; if (mem_addr_o !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL ld_addr got %h exp %h", mem_addr_o, addr & 32'hFFFF_FFFC); end
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL ld_busy got %0b exp 0", ex_ready_o); end
    for (int i = 0; i < delay; i++) begin
      mem_rdata_i = $urandom;
      tick();
      checks++; if (mem_req_o !== 1'b1 || wd_q_o !== 1'b0) begin errors++; $display("FAIL ld_wait cyc=%0d req=%0b strobe=%0b exp req=1 strobe=0", i, mem_req_o, wd_q_o); end
    end
    mem_ack_i = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = $urandom;
    m_wd = exp_v;
    checks++; if (wd_q_o !== exp_q) begin errors++; $display("FAIL ld_strobe got %0b exp %0b", wd_q_o, exp_q); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL ld_req_drop got %0b exp 0", mem_req_o); end
    if (exp_q) begin
      checks++; if (wd_o !== exp_v) begin errors++; $display("FAIL ld_data f3=%0d addr=%h rdata=%h got %h exp %h", f3, addr, rdata, wd_o, exp_v); end
      checks++; if (wd_rd_o !== rd) begin errors++; $display("FAIL ld_wd_rd got %0d exp %0d", wd_rd_o, rd); end
    end
    tick();
    checks++; if (wd_q_o !== 1'b0 || ex_ready_o !== 1'b1) begin errors++; $display("FAIL ld_finish strobe=%0b ready=%0b exp 0/1", wd_q_o, ex_ready_o); end
  endtask

  task automatic test_loads();
    logic [2:0] f3s [5];
    logic [2:0] f3;
    logic [31:0] addr;
    f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;
    load_op(5'd9, 3'd0, 32'h0000_0103, 32'h80FF_0000, 2);
    load_op(5'd9, 3'd4, 32'h0000_0103, 32'h80FF_0000, 0);
    load_op(5'd4, 3'd2, 32'h0000_0040, 32'hCAFE_F00D, MEM_TIMEOUT - 1);
    for (int i = 0; i < 30; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      do addr = $urandom; while (!load_legal(f3, addr));
      load_op(5'($urandom_range(0, 31)), f3, addr, $urandom, $urandom_range(0, MEM_TIMEOUT - 1));
    end
    // Acks while idle must be ignored.
    mem_ack_i = 1'b1;
    mem_rdata_i = $urandom;
    tick();
    tick();
    mem_ack_i = 1'b0;
    checks++; if (wd_q_o !== 1'b0 || mem_req_o !== 1'b0 || ex_ready_o !== 1'b1 || wd_o !== m_wd)
      begin errors++; $display("FAIL stray_ack strobe=%0b req=%0b ready=%0b wd=%h exp 0/0/1/%h", wd_q_o, mem_req_o, ex_ready_o, wd_o, m_wd); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL loads_no_err got %0b exp 0", err_o); end
  endtask

  task automatic bad_load(input logic [2:0] f3, input logic [31:0] addr);
    do_reset();
    issue(C_L, 5'd6, f3, addr);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL badld_err f3=%0d addr=%h got %0b exp 1", f3, addr, err_o); end
    checks++; if (mem_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin errors++; $display("FAIL badld_idle req=%0b ready=%0b exp 0/1", mem_req_o, ex_ready_o); end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    tick();
    checks++; if (mem_req_o !== 1'b0 || wd_q_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL badld_after req=%0b strobe=%0b err=%0b exp 0/0/1", mem_req_o, wd_q_o, err_o); end
  endtask

  task automatic test_bad_loads();
    logic [2:0] f3;
    logic [31:0] addr;
    bad_load(3'd2, 32'h0000_0102);
    bad_load(3'd3, 32'h0000_0100);
    bad_load(3'd1, 32'h0000_0101);
    bad_load(3'd5, 32'h0000_0203);
    for (int i = 0; i < 8; i++) begin
      do begin
        f3 = 3'($urandom);
        addr = $urandom;
      end while (load_legal(f3, addr));
      bad_load(f3, addr);
    end
  endtask

  task automatic test_timeout();
    int high;
    int guard;
    do_reset();
    issue(C_L, 5'd7, 3'd2, 32'h0000_0200);
    high = 0;
    guard = 0;
    while (mem_req_o === 1'b1 && guard < 40) begin
      high++;
      guard++;
      checks++; if (mem_addr_o !== 32'h0000_0200 || err_o !== 1'b0 || wd_q_o !== 1'b0) begin errors++; $display("FAIL to_wait addr=%h err=%0b strobe=%0b exp 200/0/0", mem_addr_o, err_o, wd_q_o); end
      tick();
    end
    checks++; if (high != MEM_TIMEOUT) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", high, MEM_TIMEOUT); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL to_err got %0b exp 1", err_o); end
    checks++; if (ex_ready_o !== 1'b1 || wd_q_o !== 1'b0) begin errors++; $display("FAIL to_idle ready=%0b strobe=%0b exp 1/0", ex_ready_o, wd_q_o); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    issue(C_L, 5'd3, 3'd2, 32'h0000_0101);
    issue(C_L, 5'd8, 3'd2, 32'h0000_0300);
    tick();
    tick();
    checks++; if (mem_req_o !== 1'b1 || err_o !== 1'b1) begin errors++; $display("FAIL rst_pre req=%0b err=%0b exp 1/1", mem_req_o, err_o); end
    reset = 1'b1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h1111_2222;
    tick();
    checks++; if (mem_req_o !== 1'b0 || err_o !== 1'b0 || wd_q_o !== 1'b0) begin errors++; $display("FAIL rst_edge req=%0b err=%0b strobe=%0b exp 0/0/0", mem_req_o, err_o, wd_q_o); end
    reset = 1'b0;
    mem_ack_i = 1'b0;
    m_wd = 32'd0;
    tick();
    checks++; if (wd_q_o !== 1'b0 || ex_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_after strobe=%0b ready=%0b req=%0b exp 0/1/0", wd_q_o, ex_ready_o, mem_req_o); end
    alu_op(C_R, 5'd12, 32'h0BAD_CAFE);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_no_write();
    test_loads();
    test_bad_loads();
    test_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
